matrix_pe_array: RTL and testbench
==================================

// Module: matrix_pe_array
// PURPOSE
//  Multi-channel successor of the single-output matrix PE. Each beat takes one neuron vector from NRAM
//  and CH weight vectors from WRAM. It computes CH signed dot products and accumulates them over the
//  number of beats given by an 8-bit uop. The finished CH-wide result is returned with valid/ready backpressure.
//  Sits between the IB uop queue, NRAM/WRAM read ports and the result writeback path.
// PARAMETERS
//  LANES  32  elements per vector beat
//  DW     16  element width (signed, two's complement)
//  CH     4   output channels (weight rows per beat)
//  ACC_W  32  accumulator/result width per channel
//  ITER_W 8   uop iteration-count width
// PORTS
//  clk                    in   1             clock; all logic posedge
//  rst                    in   1             synchronous, active-high reset
//  ib_ctl_uop             in   ITER_W        beat count N; 0 encodes 2**ITER_W
//  ib_ctl_uop_valid       in   1             uop offered
//  ib_ctl_uop_ready       out  1             uop accepted when valid&&ready
//  nram_mpe_neuron        in   LANES*DW      neuron vector, lane i = bits[i*DW+:DW]
//  nram_mpe_neuron_valid  in   1
//  nram_mpe_neuron_ready  out  1
//  wram_mpe_weight        in   CH*LANES*DW   channel c lane i = bits[(c*LANES+i)*DW+:DW]
//  wram_mpe_weight_valid  in   1
//  wram_mpe_weight_ready  out  1
//  result                 out  CH*ACC_W      channel c = bits[c*ACC_W+:ACC_W]
//  result_valid           out  1
//  result_ready           in   1
// BEHAVIOUR
//  - FSM IDLE->RUN->DRAIN->OUT->IDLE. While rst is high: state=IDLE and all outputs are 0.
//    Accumulators, beat counter and pipeline valids are cleared. rst mid-operation discards partial sums, no result.
//  - IDLE: ib_ctl_uop_ready=1. On uop handshake, latch N and clear beat counter and accumulators; go to RUN.
//  - RUN: fire = nram_valid && wram_valid. Both data readies = fire (asserted together, never singly).
//    Each fire increments the beat counter. The fire that makes the count reach N goes to DRAIN.
//    No stall penalty: the counter holds on any cycle without fire.
//  - Pipeline: stage1 registers CH adder-tree sums of LANES signed DWxDW products,
//    sign-extended to ACC_W. Stage2 adds them into the accumulators. The first beat loads instead of adding.
//  - DRAIN: waits for stage1/stage2 to empty.
//    Last fire at cycle t -> result_valid=1 at t+2, if result_ready does not stall.
//  - OUT: result_valid=1 and result stable until result_ready. On handshake go to IDLE.
//    ib_ctl_uop_ready rises the next cycle; there is no same-cycle uop overlap.
//  - Arithmetic wraps modulo 2**ACC_W; no saturation.
//  - Data beats presented outside RUN are ignored (ready=0). Uops offered outside IDLE wait (ready=0).
//  - N=0 runs 2**ITER_W beats. Counter width is ITER_W+1, so the count does not wrap.
// CONFIGURATION
//  MATRIX_PE_RELU_EN defined: each channel result is forced to 0 if negative, at the OUT register.
//  Undefined: raw signed accumulator value is output. Timing and handshake are identical in both builds.
// TESTING
//  1. Reset: rst=1 for 3 cycles mid-RUN -> all outputs 0. Next uop N=1 with all-ones data
//     gives result = LANES (32) on every channel; no stale sum.
//  2. N=4, neuron lanes=1, weight ch c lanes=c+1, valids always high -> readies high 4 cycles.
//     result ch c = 4*32*(c+1) = 128,256,384,512 at last-fire+2.
//  3. Same as 2 with wram_valid toggled 1/0 -> readies follow the fire condition only. Sums unchanged; valid delayed.
//  4. Signed: neuron=-3, weight=7, N=2 -> every ch = -1344. With MATRIX_PE_RELU_EN -> 0.
//  5. Backpressure: result_ready=0 for 5 cycles -> result_valid held and result stable, uop_ready=0.
//     Release -> uop_ready=1 next cycle.
//  6. N=0 with all-ones data -> 256 fires, result = 256*32 = 8192 per channel.
//     Also 0x7FFF*0x7FFF per lane over many beats wraps modulo 2**32.

Source files
------------

// File: rtl/matrix_pe_array.sv
// Matrix PE array: CH signed LANES-wide dot products accumulated over N beats; MATRIX_PE_RELU_EN clamps negative results to 0.
// Latency: last fired beat at cycle t gives result_valid at t+2; the result is held until result_ready, then uop_ready returns next cycle.
module matrix_pe_array #(
    parameter int LANES  = 32,
    parameter int DW     = 16,
    parameter int CH     = 4,
    parameter int ACC_W  = 32,
    parameter int ITER_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ITER_W-1:0]        ib_ctl_uop,
    input  logic                     ib_ctl_uop_valid,
    output logic                     ib_ctl_uop_ready,
    input  logic [LANES*DW-1:0]      nram_mpe_neuron,
    input  logic                     nram_mpe_neuron_valid,
    output logic                     nram_mpe_neuron_ready,
    input  logic [CH*LANES*DW-1:0]   wram_mpe_weight,
    input  logic                     wram_mpe_weight_valid,
    output logic                     wram_mpe_weight_ready,
    output logic [CH*ACC_W-1:0]      result,
    output logic                     result_valid,
    input  logic                     result_ready
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    state_t              state;
    logic [ITER_W:0]     beats;
    logic [ITER_W:0]     cnt;
    logic [ITER_W:0]     cnt_inc;
    logic                fire;
    logic                last_fire;
    logic                s1_vld;
    logic                s1_first;
    logic                s1_last;
    logic [ACC_W-1:0]    tree    [CH];
    logic [ACC_W-1:0]    s1_sum  [CH];
    logic [ACC_W-1:0]    acc     [CH];
    logic [ACC_W-1:0]    acc_nxt [CH];

    function automatic logic [ACC_W-1:0] dot(input logic [LANES*DW-1:0] n,
                                             input logic [LANES*DW-1:0] w);
        logic signed [2*DW-1:0] p;
        logic [ACC_W-1:0]       s;
        s = '0;
        for (int i = 0; i < LANES; i++) begin
            p = $signed(n[i*DW +: DW]) * $signed(w[i*DW +: DW]);
            s = s + ACC_W'(p);
        end
        return s;
    endfunction

    function automatic logic [ACC_W-1:0] post(input logic [ACC_W-1:0] v);
`ifdef MATRIX_PE_RELU_EN
        return v[ACC_W-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Both data ports are consumed together; a lone valid never produces a ready.
    assign fire      = !rst && (state == RUN) && nram_mpe_neuron_valid && wram_mpe_weight_valid;
    assign nram_mpe_neuron_ready = fire;
    assign wram_mpe_weight_ready = fire;
    assign cnt_inc   = cnt + {{ITER_W{1'b0}}, 1'b1};
    assign last_fire = fire && (cnt_inc == beats);

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            tree[c]    = dot(nram_mpe_neuron, wram_mpe_weight[c*LANES*DW +: LANES*DW]);
            acc_nxt[c] = s1_first ? s1_sum[c] : acc[c] + s1_sum[c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            ib_ctl_uop_ready <= 1'b0;
            beats            <= '0;
            cnt              <= '0;
            s1_vld           <= 1'b0;
            s1_first         <= 1'b0;
            s1_last          <= 1'b0;
            result_valid     <= 1'b0;
            result           <= '0;
            for (int c = 0; c < CH; c++) begin
                s1_sum[c] <= '0;
                acc[c]    <= '0;
            end
        end else begin
            s1_vld <= fire;
            if (fire) begin
                s1_first <= (cnt == '0);
                s1_last  <= last_fire;
                for (int c = 0; c < CH; c++)
                    s1_sum[c] <= tree[c];
            end
            if (s1_vld) begin
                for (int c = 0; c < CH; c++)
                    acc[c] <= acc_nxt[c];
            end

            case (state)
                IDLE: begin
                    ib_ctl_uop_ready <= !(ib_ctl_uop_valid && ib_ctl_uop_ready);
                    if (ib_ctl_uop_valid && ib_ctl_uop_ready) begin
                        // A zero count stands for the full 2**ITER_W beats.
                        beats <= (ib_ctl_uop == '0) ? {1'b1, {ITER_W{1'b0}}} : {1'b0, ib_ctl_uop};
                        cnt   <= '0;
                        for (int c = 0; c < CH; c++)
                            acc[c] <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (fire)
                        cnt <= cnt_inc;
                    if (last_fire)
                        state <= DRAIN;
                end
                DRAIN: begin
                    // The final sum goes straight to the output register, saving a cycle.
                    if (s1_vld && s1_last) begin
                        for (int c = 0; c < CH; c++)
                            result[c*ACC_W +: ACC_W] <= post(acc_nxt[c]);
                        result_valid <= 1'b1;
                        state        <= OUT;
                    end
                end
                OUT: begin
                    if (result_ready) begin
                        result_valid     <= 1'b0;
                        ib_ctl_uop_ready <= 1'b1;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_pe_array.sv
// Bench for matrix_pe_array: scoreboard of expected results with arrival-cycle and handshake checks.
module tb_matrix_pe_array;

    localparam int LANES  = 32;
    localparam int DW     = 16;
    localparam int CH     = 4;
    localparam int ACC_W  = 32;
    localparam int ITER_W = 8;
    localparam int RW     = CH*ACC_W;

    logic                   clk;
    logic                   rst;
    logic [ITER_W-1:0]      ib_ctl_uop;
    logic                   ib_ctl_uop_valid;
    logic                   ib_ctl_uop_ready;
    logic [LANES*DW-1:0]    nram_mpe_neuron;
    logic                   nram_mpe_neuron_valid;
    logic                   nram_mpe_neuron_ready;
    logic [CH*LANES*DW-1:0] wram_mpe_weight;
    logic                   wram_mpe_weight_valid;
    logic                   wram_mpe_weight_ready;
    logic [RW-1:0]          result;
    logic                   result_valid;
    logic                   result_ready;

    matrix_pe_array #(.LANES(LANES), .DW(DW), .CH(CH), .ACC_W(ACC_W), .ITER_W(ITER_W)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .ib_ctl_uop            (ib_ctl_uop),
        .ib_ctl_uop_valid      (ib_ctl_uop_valid),
        .ib_ctl_uop_ready      (ib_ctl_uop_ready),
        .nram_mpe_neuron       (nram_mpe_neuron),
        .nram_mpe_neuron_valid (nram_mpe_neuron_valid),
        .nram_mpe_neuron_ready (nram_mpe_neuron_ready),
        .wram_mpe_weight       (wram_mpe_weight),
        .wram_mpe_weight_valid (wram_mpe_weight_valid),
        .wram_mpe_weight_ready (wram_mpe_weight_ready),
        .result                (result),
        .result_valid          (result_valid),
        .result_ready          (result_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int stall    = 0;

    logic [RW-1:0] exp_q [$];
    int            cyc_q [$];

    task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [ACC_W-1:0] ref_dot(input logic [LANES*DW-1:0] n,
                                                 input logic [LANES*DW-1:0] w);
        logic signed [DW-1:0] a;
        logic signed [DW-1:0] b;
        longint               s;
        s = 0;
        for (int i = 0; i < LANES; i++) begin
            a = n[i*DW +: DW];
            b = w[i*DW +: DW];
            s = s + longint'(a) * longint'(b);
        end
        return s[ACC_W-1:0];
    endfunction

    // Result monitor: checks arrival cycle, value, hold under backpressure and uop_ready timing.
    initial begin
        logic [RW-1:0] held;
        logic [RW-1:0] e;
        int            ec;
        bit            seen;
        bit            after;
        seen = 0;
        after = 0;
        held = '0;
        result_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 0;
                after = 0;
            end else if (result_valid) begin
                if (!seen) begin
                    seen = 1;
                    held = result;
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        e  = exp_q.pop_front();
                        ec = cyc_q.pop_front();
                        check("result", result, e);
                        check("latency", cyc, ec);
                    end
                end else begin
                    check("result_hold", result, held);
                    check("uop_rdy_in_out", ib_ctl_uop_ready, 0);
                end
                if (stall > 0) begin
                    result_ready = 1'b0;
                    stall--;
                end else begin
                    result_ready = 1'b1;
                    after = 1;
                end
            end else begin
                if (after)
                    check("uop_rdy_rise", ib_ctl_uop_ready, 1);
                after = 0;
                seen = 0;
            end
        end
    end

    task automatic send_uop(input int n);
        int k;
        k = 0;
        while (!ib_ctl_uop_ready && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("uop_wait", ib_ctl_uop_ready, 1);
        ib_ctl_uop       = ITER_W'(n);
        ib_ctl_uop_valid = 1'b1;
        @(negedge clk);
        ib_ctl_uop_valid = 1'b0;
    endtask

    task automatic run_job(input int n, input int nval, input int wval,
                           input bit wscale, input bit rnd, input bit toggle);
        logic [ACC_W-1:0] e [CH];
        logic [RW-1:0]    ev;
        logic [DW-1:0]    nv16;
        logic [DW-1:0]    wv16;
        int               beats;
        int               fires;
        int               k;
        beats = (n == 0) ? (1 << ITER_W) : n;
        for (int c = 0; c < CH; c++) e[c] = '0;
        send_uop(n);
        fires = 0;
        k = 0;
        while (fires < beats && k < 4000) begin
            nv16 = DW'(nval);
            for (int i = 0; i < LANES; i++)
                nram_mpe_neuron[i*DW +: DW] = rnd ? DW'($urandom) : nv16;
            for (int c = 0; c < CH; c++) begin
                wv16 = wscale ? DW'(wval * (c + 1)) : DW'(wval);
                for (int i = 0; i < LANES; i++)
                    wram_mpe_weight[(c*LANES+i)*DW +: DW] = rnd ? DW'($urandom) : wv16;
            end
            nram_mpe_neuron_valid = 1'b1;
            wram_mpe_weight_valid = toggle ? (k % 2 == 0) : 1'b1;
            #1;
            check("nram_rdy", nram_mpe_neuron_ready, wram_mpe_weight_valid);
            check("wram_rdy", wram_mpe_weight_ready, wram_mpe_weight_valid);
            if (wram_mpe_weight_valid) begin
                for (int c = 0; c < CH; c++)
                    e[c] = e[c] + ref_dot(nram_mpe_neuron, wram_mpe_weight[c*LANES*DW +: LANES*DW]);
                fires++;
                if (fires == beats) begin
                    for (int c = 0; c < CH; c++) begin
`ifdef MATRIX_PE_RELU_EN
                        if (e[c][ACC_W-1]) e[c] = '0;
`endif
                        ev[c*ACC_W +: ACC_W] = e[c];
                    end
                    exp_q.push_back(ev);
                    cyc_q.push_back(cyc + 2);
                end
            end
            @(negedge clk);
            k++;
        end
        if (fires < beats) check("fire_timeout", 0, 1);
        nram_mpe_neuron_valid = 1'b0;
        wram_mpe_weight_valid = 1'b0;
    endtask

    // Offers data beats while the job drains; none may be accepted outside RUN.
    task automatic wait_idle();
        int k;
        k = 0;
        nram_mpe_neuron_valid = 1'b1;
        wram_mpe_weight_valid = 1'b1;
        while (!(exp_q.size() == 0 && ib_ctl_uop_ready && !result_valid) && k < 1000) begin
            #1;
            check("rdy_outside_run", {nram_mpe_neuron_ready, wram_mpe_weight_ready}, 0);
            @(negedge clk);
            k++;
        end
        if (k >= 1000) check("idle_timeout", 0, 1);
        nram_mpe_neuron_valid = 1'b0;
        wram_mpe_weight_valid = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_result", result, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_uop_ready", ib_ctl_uop_ready, 0);
        check("rst_nram_ready", nram_mpe_neuron_ready, 0);
        check("rst_wram_ready", wram_mpe_weight_ready, 0);
    endtask

    initial begin
        rst = 1'b1;
        ib_ctl_uop = '0;
        ib_ctl_uop_valid = 1'b0;
        nram_mpe_neuron = '0;
        nram_mpe_neuron_valid = 1'b0;
        wram_mpe_weight = '0;
        wram_mpe_weight_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of a run: partial sums must vanish.
        send_uop(8);
        nram_mpe_neuron = {LANES{16'sd1}};
        wram_mpe_weight = {CH*LANES{16'sd1}};
        nram_mpe_neuron_valid = 1'b1;
        wram_mpe_weight_valid = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check_reset_outputs();
        end
        rst = 1'b0;
        nram_mpe_neuron_valid = 1'b0;
        wram_mpe_weight_valid = 1'b0;
        @(negedge clk);
        run_job(1, 1, 1, 0, 0, 0);
        wait_idle();

        run_job(4, 1, 1, 1, 0, 0);      // 128, 256, 384, 512
        wait_idle();
        run_job(4, 1, 1, 1, 0, 1);      // same sums, weight valid toggling
        wait_idle();
        run_job(2, -3, 7, 0, 0, 0);     // -1344 per channel (0 with ReLU)
        wait_idle();
        stall = 5;
        run_job(3, 0, 0, 0, 1, 0);      // random data under result backpressure
        wait_idle();
        run_job(0, 1, 1, 0, 0, 0);      // 256 beats -> 8192
        wait_idle();
        run_job(0, 32'h7fff, 32'h7fff, 0, 0, 0);  // wraps modulo 2**32
        wait_idle();
        run_job(5, 0, 0, 0, 1, 1);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got cycle %0d expected end before it", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

endmodule
